// File: rtl/bus_arbiter.sv
// Serial bus arbiter: grants the bus to initiator 1, initiator 2 or the split target.
// Tracks one outstanding split transaction and bounds every tenure with a watchdog.
module bus_arbiter #(
    parameter int TIMEOUT = 64,
    parameter bit RR_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init1_req,
    input  logic       init2_req,
    input  logic       split_req,
    input  logic       split_ack_in,
    input  logic       txn_done,
    output logic       init1_grant,
    output logic       init2_grant,
    output logic       split_grant,
    output logic [1:0] owner,
    output logic       split_pending,
    output logic [1:0] split_owner,
    output logic       timeout,
    output logic       protocol_err
);

    // State codes double as the owner mux select.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] OWN1  = 2'b01;
    localparam logic [1:0] OWN2  = 2'b10;
    localparam logic [1:0] SPLIT = 2'b11;

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    logic [1:0]      state_reg, state_next;
    logic            split_pending_reg, split_pending_next;
    logic [1:0]      split_owner_reg, split_owner_next;
    logic            last2_reg, last2_next;
    logic            timeout_reg, timeout_next;
    logic            protocol_err_reg, protocol_err_next;
    logic [2:0]      grant_reg, grant_next;
    logic [WD_W-1:0] wd_reg;
    logic [1:0]      req_vec, elig;
    logic            wd_expire, owner_req;

    assign req_vec = {init2_req, init1_req};

    // An initiator waiting on its own split data must not re-enter arbitration.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = req_vec[gi] &&
                              !(split_pending_reg && (split_owner_reg == 2'(gi + 1)));
        end
        for (gi = 0; gi < 3; gi++) begin : g_grant
            assign grant_next[gi] = (state_next == 2'(gi + 1));
        end
    endgenerate

    assign wd_expire = (TIMEOUT > 0) && (wd_reg == WD_LIMIT);
    assign owner_req = (state_reg == OWN1) ? init1_req : init2_req;

    always_comb begin
        state_next         = state_reg;
        split_pending_next = split_pending_reg;
        split_owner_next   = split_owner_reg;
        last2_next         = last2_reg;
        timeout_next       = 1'b0;
        protocol_err_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (split_req && split_pending_reg) begin
                    state_next = SPLIT;
                end else begin
                    if (split_req) begin
                        protocol_err_next = 1'b1;
                    end
                    if (elig == 2'b11) begin
                        state_next = (RR_EN && !last2_reg) ? OWN2 : OWN1;
                    end else if (elig[0]) begin
                        state_next = OWN1;
                    end else if (elig[1]) begin
                        state_next = OWN2;
                    end
                    if (state_next == OWN1) begin
                        last2_next = 1'b0;
                    end else if (state_next == OWN2) begin
                        last2_next = 1'b1;
                    end
                end
            end
            OWN1, OWN2: begin
                if (split_ack_in) begin
                    // A second split while one is outstanding is dropped.
                    if (split_pending_reg) begin
                        protocol_err_next = 1'b1;
                    end else begin
                        split_pending_next = 1'b1;
                        split_owner_next   = state_reg;
                    end
                    state_next = IDLE;
                end else if (txn_done || !owner_req) begin
                    state_next = IDLE;
                end else if (wd_expire) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                if (txn_done || wd_expire) begin
                    timeout_next       = !txn_done;
                    split_pending_next = 1'b0;
                    split_owner_next   = 2'b00;
                    state_next         = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            split_pending_reg <= 1'b0;
            split_owner_reg   <= 2'b00;
            last2_reg         <= 1'b1;
            timeout_reg       <= 1'b0;
            protocol_err_reg  <= 1'b0;
            grant_reg         <= 3'b000;
            wd_reg            <= '0;
        end else begin
            state_reg         <= state_next;
            split_pending_reg <= split_pending_next;
            split_owner_reg   <= split_owner_next;
            last2_reg         <= last2_next;
            timeout_reg       <= timeout_next;
            protocol_err_reg  <= protocol_err_next;
            grant_reg         <= grant_next;
            // Tenures are always separated by an IDLE cycle, which clears the count.
            if (state_reg == IDLE) begin
                wd_reg <= '0;
            end else if (wd_reg != '1) begin
                wd_reg <= wd_reg + 1'b1;
            end
        end
    end

    assign init1_grant   = grant_reg[0];
    assign init2_grant   = grant_reg[1];
    assign split_grant   = grant_reg[2];
    assign owner         = state_reg;
    assign split_pending = split_pending_reg;
    assign split_owner   = split_owner_reg;
    assign timeout       = timeout_reg;
    assign protocol_err  = protocol_err_reg;

endmodule
